pulse_accum_gen: RTL and testbench

PULSE_ACCUM_GEN -- requirements
Module: pulse_accum_gen

---
 rtl/pulse_accum_gen.sv | 219 +++++++++++++++++++++
 tb/tb_pulse_accum_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_accum_gen.sv
// rtl/pulse_accum_gen.sv - LFSR-placed events accumulate an fp32 shape into pulse BRAM (optional PULSE_ACCUM_GEN_STATS_EN)

module fp32_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic [31:0]       x, y;
  logic [7:0]        d;
  logic [26:0]       mx, my, ms, mask;
  logic [27:0]       r;
  logic [24:0]       mant;
  logic signed [9:0] e;
  logic              inc;

  // Round-to-nearest-even add; denormal inputs/results flush to zero, overflow gives infinity.
  always_comb begin
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    mx   = {1'b1, x[22:0], 3'b000};
    my   = {1'b1, y[22:0], 3'b000};
    d    = x[30:23] - y[30:23];
    mask = '0;
    ms   = 27'd1;
    mant = '0;
    inc  = 1'b0;
    sum  = '0;
    e    = $signed({2'b00, x[30:23]});
    if (d < 8'd27) begin
      mask = (27'd1 << d) - 27'd1;
      ms   = (my >> d) | {26'd0, |(my & mask)};
    end
    if (x[31] ^ y[31]) r = {1'b0, mx} - {1'b0, ms};
    else               r = {1'b0, mx} + {1'b0, ms};
    if (r[27]) begin
      r = {1'b0, r[27:2], r[1] | r[0]};
      e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!r[26] && r != 28'd0) begin
          r = r << 1;
          e = e - 10'sd1;
        end
      end
    end
    inc  = r[2] & (r[1] | r[0] | r[3]);
    mant = {1'b0, r[26:3]} + {24'd0, inc};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'sd1;
    end
    if (y[30:23] == 8'd0)                  sum = (x[30:23] == 8'd0) ? 32'd0 : x;
    else if (r == 28'd0 || e <= 10'sd0)    sum = 32'd0;
    else if (e >= 10'sd255)                sum = {x[31], 8'hFF, 23'd0};
    else                                   sum = {x[31], e[7:0], mant[22:0]};
  end
endmodule

module pulse_accum_gen #(
  parameter int                LFSR_W    = 11,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 11'h500,
  parameter int                SHAPE_LEN = 50,
  parameter logic [LFSR_W-1:0] SEED      = 11'h555
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cps,
  output logic        busy,
  output logic        done,
  input  logic        shape_we,
  input  logic [7:0]  shape_addr,
  input  logic [31:0] shape_data,
  output logic [31:0] pin_addr,
  output logic [31:0] pin_din,
  output logic        pin_we,
  output logic        pin_en,
  output logic [31:0] pls_addr,
  output logic [31:0] pls_din,
  output logic        pls_we,
  output logic        pls_en,
  input  logic [31:0] pls_dout
`ifdef PULSE_ACCUM_GEN_STATS_EN
  ,
  output logic [31:0] evt_total,
  output logic [15:0] overlap_cnt
`endif
);
  localparam int                SH_AW    = (SHAPE_LEN > 1) ? $clog2(SHAPE_LEN) : 1;
  localparam logic [7:0]        LAST_TAP = 8'(SHAPE_LEN - 1);
  localparam logic [LFSR_W-1:0] SEED_NZ  = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [2:0] {IDLE, PIN, RD, WT, WR, NXT} state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr, evt_idx, pidx;
  logic [7:0]        tap;
  logic [31:0]       evt_left, tap_addr, shape_k, add_sum;
  logic              done_zero;
  logic [31:0]       shape [0:(1<<SH_AW)-1];

  assign pidx     = evt_idx + LFSR_W'(tap);
  assign tap_addr = 32'({pidx, 2'b00});
  assign shape_k  = shape[tap[SH_AW-1:0]];

  fp32_adder u_add (
    .a   (pls_dout),
    .b   (shape_k),
    .sum (add_sum)
  );

  // Shape table: not reset, writable any time, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (shape_we && ({1'b0, shape_addr} < 9'(SHAPE_LEN)))
      shape[shape_addr[SH_AW-1:0]] <= shape_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Event position LFSR, tap index, remaining events and the cps==0 done strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED_NZ;
      evt_idx   <= '0;
      tap       <= '0;
      evt_left  <= '0;
      done_zero <= 1'b0;
    end else begin
      done_zero <= (state == IDLE) && start && (cps == 32'd0);
      case (state)
        IDLE: if (start) evt_left <= cps;
        PIN: begin
          evt_idx <= lfsr;
          lfsr    <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
          tap     <= '0;
        end
        WR:      tap      <= tap + 8'd1;
        NXT:     evt_left <= evt_left - 32'd1;
        default: ;
      endcase
    end
  end

  // Next state and BRAM strobes; every strobe and address is 0 unless its state drives it.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = done_zero;
    pin_addr  = '0;
    pin_din   = '0;
    pin_we    = 1'b0;
    pin_en    = 1'b0;
    pls_addr  = '0;
    pls_din   = '0;
    pls_we    = 1'b0;
    pls_en    = 1'b0;
    case (state)
      IDLE: if (start && cps != 32'd0) state_nxt = PIN;
      PIN: begin
        pin_addr  = 32'({lfsr, 2'b00});
        pin_din   = 32'd1;
        pin_we    = 1'b1;
        pin_en    = 1'b1;
        state_nxt = RD;
      end
      RD: begin
        pls_addr  = tap_addr;
        pls_en    = 1'b1;
        state_nxt = WT;
      end
      WT: begin
        pls_addr  = tap_addr;
        state_nxt = WR;
      end
      WR: begin
        pls_addr  = tap_addr;
        pls_din   = add_sum;
        pls_en    = 1'b1;
        pls_we    = 1'b1;
        state_nxt = (tap == LAST_TAP) ? NXT : RD;
      end
      NXT: begin
        if (evt_left == 32'd1) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          state_nxt = PIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PULSE_ACCUM_GEN_STATS_EN
  // Saturating counts of generated events and of events landing on nonzero pulse data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_total   <= '0;
      overlap_cnt <= '0;
    end else begin
      if (state == PIN && evt_total != '1)
        evt_total <= evt_total + 32'd1;
      if (state == WR && tap == 8'd0 && pls_dout != 32'd0 && overlap_cnt != '1)
        overlap_cnt <= overlap_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_pulse_accum_gen.sv
// tb/tb_pulse_accum_gen.sv - scoreboard bench for pulse_accum_gen
`timescale 1ns/1ps
module tb_pulse_accum_gen;
  localparam int L     = 50;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n, start, start_w, shape_we;
  logic [31:0] cps, shape_data;
  logic [7:0]  shape_addr;
  logic        busy, done, pin_we, pin_en, pls_we, pls_en;
  logic [31:0] pin_addr, pin_din, pls_addr, pls_din;
  logic [31:0] pls_dout = '0;
  logic        w_busy, w_done, w_pin_we, w_pin_en, w_pls_we, w_pls_en;
  logic [31:0] w_pin_addr, w_pin_din, w_pls_addr, w_pls_din;
  logic [31:0] w_pls_dout = '0;
`ifdef PULSE_ACCUM_GEN_STATS_EN
  logic [31:0] evt_total, w_evt_total;
  logic [15:0] overlap_cnt, w_overlap_cnt;
`endif

  always #5 clk = ~clk;

  pulse_accum_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cps(cps), .busy(busy), .done(done),
    .shape_we(shape_we), .shape_addr(shape_addr), .shape_data(shape_data),
    .pin_addr(pin_addr), .pin_din(pin_din), .pin_we(pin_we), .pin_en(pin_en),
    .pls_addr(pls_addr), .pls_din(pls_din), .pls_we(pls_we), .pls_en(pls_en), .pls_dout(pls_dout)
`ifdef PULSE_ACCUM_GEN_STATS_EN
    , .evt_total(evt_total), .overlap_cnt(overlap_cnt)
`endif
  );

  pulse_accum_gen #(.SEED(11'h7FF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .cps(cps), .busy(w_busy), .done(w_done),
    .shape_we(shape_we), .shape_addr(shape_addr), .shape_data(shape_data),
    .pin_addr(w_pin_addr), .pin_din(w_pin_din), .pin_we(w_pin_we), .pin_en(w_pin_en),
    .pls_addr(w_pls_addr), .pls_din(w_pls_din), .pls_we(w_pls_we), .pls_en(w_pls_en), .pls_dout(w_pls_dout)
`ifdef PULSE_ACCUM_GEN_STATS_EN
    , .evt_total(w_evt_total), .overlap_cnt(w_overlap_cnt)
`endif
  );

  logic [31:0] pmem [0:DEPTH-1];
  logic [31:0] pinmem [0:DEPTH-1];
  logic [31:0] wmem [0:DEPTH-1];
  logic [31:0] mpls [0:DEPTH-1];
  logic [31:0] mshape [0:L-1];
  real vals [0:7] = '{0.25, 0.5, 0.75, 1.0, 1.25, 1.5, 2.0, 3.0};

  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; } item_t;
  item_t sbq[$];
  item_t mon_it;
  int    mon_kind;
  int    mlfsr, cyc = 0, n_chk = 0, n_fail = 0, w_writes = 0, w_done_cnt = 0, we_seen;
  bit    sb_on;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic real f2r(logic [31:0] f);
    real m;
    int  ex;
    if (f[30:23] == 8'd0) return 0.0;
    m  = 1.0 + real'(f[22:0]) / 8388608.0;
    ex = int'(f[30:23]) - 127;
    while (ex > 0) begin m = m * 2.0; ex--; end
    while (ex < 0) begin m = m / 2.0; ex++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(real v);
    logic        s;
    int          ex;
    real         m;
    logic [22:0] fr;
    if (v == 0.0) return 32'd0;
    s  = (v < 0.0);
    m  = s ? -v : v;
    ex = 127;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    fr = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(ex), fr};
  endfunction

  // Reference: each event pins its index, then adds the shape over the next L words (wrapping).
  task automatic model_frame(input int n, input int c_s);
    int    e, idx;
    item_t it;
    for (int v = 0; v < n; v++) begin
      e = mlfsr;
      it.kind = 0; it.addr = 32'(e * 4); it.data = 32'd1;
      sbq.push_back(it);
      mlfsr = ((mlfsr << 1) & 'h7FF) | (((mlfsr >> 10) ^ (mlfsr >> 8)) & 1);
      for (int k = 0; k < L; k++) begin
        idx = (e + k) % DEPTH;
        mpls[idx] = r2f(f2r(mpls[idx]) + f2r(mshape[k]));
        it.kind = 1; it.addr = 32'(idx * 4); it.data = mpls[idx];
        sbq.push_back(it);
      end
    end
    it.kind = 2; it.addr = 32'd0; it.data = 32'(c_s + ((n == 0) ? 1 : n * (3 * L + 2)));
    sbq.push_back(it);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pls_en) begin
      if (pls_we) pmem[pls_addr[12:2]] <= pls_din;
      else        pls_dout <= pmem[pls_addr[12:2]];
    end
    if (pin_en && pin_we) pinmem[pin_addr[12:2]] <= pin_din;
    if (w_pls_en) begin
      if (w_pls_we) wmem[w_pls_addr[12:2]] <= w_pls_din;
      else          w_pls_dout <= wmem[w_pls_addr[12:2]];
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_pls_en) chk("w_addr_range", 32'({w_pls_addr[31:13], w_pls_addr[1:0]}), 32'd0);
    if (rst_n && w_pls_en && w_pls_we) w_writes++;
    if (rst_n && w_done) w_done_cnt++;
    if (rst_n && sb_on) begin
      if (!busy) chk("idle_enables", 32'({pin_en, pin_we, pls_en, pls_we}), 32'd0);
      if (pls_en) chk("pls_addr_hi", 32'(pls_addr[31:13]), 32'd0);
      if (pin_we || (pls_en && pls_we) || done) begin
        mon_kind = pin_we ? 0 : (done ? 2 : 1);
        if (sbq.size() == 0) begin
          chk("sb_unexpected_output", 32'(mon_kind), 32'hFFFFFFFF);
        end else begin
          mon_it = sbq.pop_front();
          chk("sb_kind", 32'(mon_kind), 32'(mon_it.kind));
          if (mon_kind == mon_it.kind) begin
            if (mon_kind == 2) begin
              chk("done_cycle", 32'(cyc), mon_it.data);
            end else if (mon_kind == 0) begin
              chk("pin_addr", pin_addr, mon_it.addr);
              chk("pin_din", pin_din, mon_it.data);
            end else begin
              chk("pls_addr", pls_addr, mon_it.addr);
              chk("pls_din", pls_din, mon_it.data);
            end
          end
        end
      end
    end
  end

  task automatic do_start(input int n, input bit model);
    @(negedge clk);
    start = 1'b1;
    cps   = 32'(n);
    if (model) model_frame(n, cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb(input string name, input int budget);
    int i = 0;
    while (sbq.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mlfsr = 'h555;
  endtask

  task automatic write_shape(input int k, input logic [31:0] v);
    @(negedge clk);
    shape_we   = 1'b1;
    shape_addr = 8'(k);
    shape_data = v;
    if (k < L) mshape[k] = v;
    @(negedge clk);
    shape_we = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i;
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0; cps = '0;
    shape_we = 1'b0; shape_addr = '0; shape_data = '0; sb_on = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      pmem[j] = '0; pinmem[j] = '0; wmem[j] = '0; mpls[j] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({done, pin_en, pin_we, pls_en, pls_we}), 32'd0);
    rst_n = 1'b1;
    mlfsr = 'h555;
    @(negedge clk);
    chk("post_rst_busy_done", 32'({busy, done}), 32'd0);
    chk("post_rst_addr", pin_addr | pls_addr, 32'd0);
    chk("post_rst_din", pin_din | pls_din, 32'd0);
    sb_on = 1'b1;

    for (int k = 0; k < L; k++) write_shape(k, 32'h3F800000);
    write_shape(67, 32'h40400000);

    @(negedge clk);
    start = 1'b1; start_w = 1'b1; cps = 32'd1;
    model_frame(1, cyc);
    @(negedge clk);
    start = 1'b0; start_w = 1'b0;
    wait_sb("frame1_timeout", 200);
    chk("pin_word_555", pinmem['h555], 32'd1);
    chk("pls_word_555", pmem['h555], 32'h3F800000);
    chk("pls_word_586", pmem['h586], 32'h3F800000);
    chk("pls_word_587", pmem['h587], 32'd0);
    chk("pls_word_554", pmem['h554], 32'd0);
    chk("wrap_done", 32'(w_done_cnt), 32'd1);
    chk("wrap_writes", 32'(w_writes), 32'd50);
    chk("wrap_word_7ff", wmem[2047], 32'h3F800000);
    chk("wrap_word_0", wmem[0], 32'h3F800000);
    chk("wrap_word_48", wmem[48], 32'h3F800000);
    chk("wrap_word_49", wmem[49], 32'd0);

    do_reset();
    do_start(1, 1'b1);
    wait_sb("frame2_timeout", 200);
    chk("overlap_555", pmem['h555], 32'h40000000);
    chk("overlap_586", pmem['h586], 32'h40000000);
`ifdef PULSE_ACCUM_GEN_STATS_EN
    chk("stats_overlap", 32'(overlap_cnt), 32'd1);
`endif

    do_start(0, 1'b1);
    chk("zero_cps_busy", 32'(busy), 32'd0);
    wait_sb("zero_cps_timeout", 10);

    sb_on = 1'b0;
    do_start(1, 1'b0);
    i = 0;
    while (!(pls_en && !pls_we) && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("abort_rd_seen", 32'(pls_en && !pls_we), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_strobes", 32'({pls_en, pls_we, pin_en, pin_we}), 32'd0);
    we_seen = 0;
    repeat (3) begin @(negedge clk); if (pls_we) we_seen++; end
    rst_n = 1'b1;
    mlfsr = 'h555;
    repeat (6) begin @(negedge clk); if (pls_we) we_seen++; end
    chk("abort_no_write", 32'(we_seen), 32'd0);
    sb_on = 1'b1;

    do_start(3, 1'b1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    cps   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_sb("busy_start_timeout", 3 * 152 + 50);
`ifdef PULSE_ACCUM_GEN_STATS_EN
    chk("stats_evt_total", evt_total, 32'd3);
`endif

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < L; k++) write_shape(k, r2f(vals[$urandom_range(0, 7)]));
      n = $urandom_range(0, 3);
      do_start(n, 1'b1);
      wait_sb("rand_frame_timeout", n * 152 + 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
